// File: rtl/d16_bus_pkg.sv
// Shared widths, arbiter state encoding and the per-master request bundle for the d16 system bus.
package d16_bus_pkg;
    localparam int ADDR_W = 16;
    localparam int DAT_W  = 16;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              cyc;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DAT_W-1:0]  dat;
    } req_t;
endpackage

// File: rtl/bus_arbiter_if.sv
// Both d16 master ports plus the shared bus side of the arbiter.
// The master modport drives requests; the slave modport is the arbiter's view.
interface bus_arbiter_if;
    import d16_bus_pkg::*;

    logic              i_m0_cyc;
    logic              i_m0_we;
    logic [ADDR_W-1:0] i_m0_addr;
    logic [DAT_W-1:0]  i_m0_dat;
    logic [DAT_W-1:0]  o_m0_dat;
    logic              o_m0_gnt;

    logic              i_m1_cyc;
    logic              i_m1_we;
    logic [ADDR_W-1:0] i_m1_addr;
    logic [DAT_W-1:0]  i_m1_dat;
    logic [DAT_W-1:0]  o_m1_dat;
    logic              o_m1_gnt;

    logic              o_wb_cyc;
    logic              o_wb_we;
    logic [ADDR_W-1:0] o_wb_addr;
    logic [DAT_W-1:0]  o_wb_dat;
    logic [DAT_W-1:0]  i_wb_dat;

    modport master (
        output i_m0_cyc, i_m0_we, i_m0_addr, i_m0_dat,
        output i_m1_cyc, i_m1_we, i_m1_addr, i_m1_dat,
        output i_wb_dat,
        input  o_m0_dat, o_m0_gnt, o_m1_dat, o_m1_gnt,
        input  o_wb_cyc, o_wb_we, o_wb_addr, o_wb_dat
    );

    modport slave (
        input  i_m0_cyc, i_m0_we, i_m0_addr, i_m0_dat,
        input  i_m1_cyc, i_m1_we, i_m1_addr, i_m1_dat,
        input  i_wb_dat,
        output o_m0_dat, o_m0_gnt, o_m1_dat, o_m1_gnt,
        output o_wb_cyc, o_wb_we, o_wb_addr, o_wb_dat
    );
endinterface

// File: rtl/arb_hold_timer.sv
// Counts contended cycles of the current grant; flags the cycle that must hand the bus over.
// Latency: count updates on the edge; o_expire is combinational from count and contention.
// No backpressure: clear has priority over increment, count saturates at 255.
module arb_hold_timer
    import d16_bus_pkg::*;
#(
    parameter int MAX_HOLD = 0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_contended,
    output logic o_expire
);
    // With MAX_HOLD=0 the limit wraps to 8'hFF but is masked off by the enable term.
    localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            count <= '0;
        end else if (i_contended && (count != {HOLD_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign o_expire = (MAX_HOLD != 0) && (count == LIMIT) && i_contended;
endmodule

// File: rtl/bus_arbiter.sv
// Two-master d16 bus arbiter; BUS_ARBITER_RR_EN selects round-robin ties, else m0 has priority.
// Latency: grant is registered, one cycle after cyc; bus mux and read data are combinational.
// No backpressure: a master stalls while its grant is low; MAX_HOLD bounds a contended hold.
module bus_arbiter
    import d16_bus_pkg::*;
#(
    parameter int MAX_HOLD = 0
) (
    input  logic           i_clk,
    input  logic           i_reset,
    bus_arbiter_if.slave   bus
);
    arb_state_t state;
    arb_state_t state_next;
    logic       last_gnt;
    logic       tie_to_m1;
    logic       contended;
    logic       expire;
    req_t       m0_req;
    req_t       m1_req;
    req_t       sel_req;

    assign m0_req = {bus.i_m0_cyc, bus.i_m0_we, bus.i_m0_addr, bus.i_m0_dat};
    assign m1_req = {bus.i_m1_cyc, bus.i_m1_we, bus.i_m1_addr, bus.i_m1_dat};

`ifdef BUS_ARBITER_RR_EN
    assign tie_to_m1 = ~last_gnt;
`else
    // last_gnt is still tracked here, fixed priority simply masks it out.
    assign tie_to_m1 = last_gnt & 1'b0;
`endif

    assign contended = ((state == GNT0) && bus.i_m1_cyc) ||
                       ((state == GNT1) && bus.i_m0_cyc);

    arb_hold_timer #(
        .MAX_HOLD (MAX_HOLD)
    ) u_timer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (state_next != state),
        .i_contended (contended),
        .o_expire    (expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_next;
            if (state_next == GNT0) begin
                last_gnt <= 1'b0;
            end else if (state_next == GNT1) begin
                last_gnt <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.i_m0_cyc && bus.i_m1_cyc) begin
                    state_next = tie_to_m1 ? GNT1 : GNT0;
                end else if (bus.i_m0_cyc) begin
                    state_next = GNT0;
                end else if (bus.i_m1_cyc) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (!bus.i_m0_cyc) begin
                    state_next = bus.i_m1_cyc ? GNT1 : IDLE;
                end else if (expire) begin
                    state_next = GNT1;
                end
            end
            GNT1: begin
                if (!bus.i_m1_cyc) begin
                    state_next = bus.i_m0_cyc ? GNT0 : IDLE;
                end else if (expire) begin
                    state_next = GNT0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_req      = '0;
        bus.o_m0_dat = '0;
        bus.o_m1_dat = '0;
        case (state)
            GNT0: begin
                sel_req      = m0_req;
                bus.o_m0_dat = bus.i_wb_dat;
            end
            GNT1: begin
                sel_req      = m1_req;
                bus.o_m1_dat = bus.i_wb_dat;
            end
            default: ;
        endcase
    end

    assign bus.o_m0_gnt  = (state == GNT0);
    assign bus.o_m1_gnt  = (state == GNT1);
    assign bus.o_wb_cyc  = sel_req.cyc;
    assign bus.o_wb_we   = sel_req.we;
    assign bus.o_wb_addr = sel_req.addr;
    assign bus.o_wb_dat  = sel_req.dat;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=0) share stimulus and are
// checked against a grant-ownership reference model, a vector table and corner-case sequences.
module tb_bus_arbiter;
`ifdef BUS_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        c0, c1, we0, we1;
    logic [15:0] a0, a1, d0, d1, wbd;

    bus_arbiter_if ba();
    bus_arbiter_if bz();

    assign ba.i_m0_cyc = c0;  assign ba.i_m0_we = we0; assign ba.i_m0_addr = a0; assign ba.i_m0_dat = d0;
    assign ba.i_m1_cyc = c1;  assign ba.i_m1_we = we1; assign ba.i_m1_addr = a1; assign ba.i_m1_dat = d1;
    assign ba.i_wb_dat = wbd;
    assign bz.i_m0_cyc = c0;  assign bz.i_m0_we = we0; assign bz.i_m0_addr = a0; assign bz.i_m0_dat = d0;
    assign bz.i_m1_cyc = c1;  assign bz.i_m1_we = we1; assign bz.i_m1_addr = a1; assign bz.i_m1_dat = d1;
    assign bz.i_wb_dat = wbd;

    bus_arbiter #(.MAX_HOLD(4)) u_a (.i_clk(clk), .i_reset(rst), .bus(ba));
    bus_arbiter #(.MAX_HOLD(0)) u_z (.i_clk(clk), .i_reset(rst), .bus(bz));

    logic [67:0] act_a, act_z;
    assign act_a = {ba.o_m0_gnt, ba.o_m1_gnt, ba.o_wb_cyc, ba.o_wb_we, ba.o_wb_addr,
                    ba.o_wb_dat, ba.o_m0_dat, ba.o_m1_dat};
    assign act_z = {bz.o_m0_gnt, bz.o_m1_gnt, bz.o_wb_cyc, bz.o_wb_we, bz.o_wb_addr,
                    bz.o_wb_dat, bz.o_m0_dat, bz.o_m1_dat};

    // Reference: who owns the bus (-1 none), who owned it last, contended cycles in this grant.
    typedef struct {
        int own;
        int last;
        int held;
    } mdl_t;

    mdl_t ma, mz;
    int   total = 0;
    int   bad   = 0;

    function automatic mdl_t mdl_step(mdl_t s, int max_hold, bit r, bit q0, bit q1);
        mdl_t    n;
        bit [1:0] want;
        int      other;
        want = {q1, q0};
        n = s;
        if (r) begin
            n.own = -1; n.last = 1; n.held = 0;
            return n;
        end
        if (s.own < 0) begin
            if (q0 && q1)  n.own = RR ? (1 - s.last) : 0;
            else if (q0)   n.own = 0;
            else if (q1)   n.own = 1;
        end else begin
            other = 1 - s.own;
            if (!want[s.own])
                n.own = want[other] ? other : -1;
            else if (want[other] && max_hold != 0 && s.held + 1 == max_hold)
                n.own = other;
            if (want[other]) n.held = (s.held >= 255) ? 255 : s.held + 1;
        end
        if (n.own != s.own) n.held = 0;
        if (n.own >= 0) n.last = n.own;
        return n;
    endfunction

    function automatic logic [67:0] expect_out(mdl_t s);
        logic        g0, g1, cyc, we;
        logic [15:0] ad, dt, r0, r1;
        g0 = (s.own == 0); g1 = (s.own == 1);
        cyc = 1'b0; we = 1'b0; ad = '0; dt = '0; r0 = '0; r1 = '0;
        if (g0) begin cyc = c0; we = we0; ad = a0; dt = d0; r0 = wbd; end
        if (g1) begin cyc = c1; we = we1; ad = a1; dt = d1; r1 = wbd; end
        return {g0, g1, cyc, we, ad, dt, r0, r1};
    endfunction

    task automatic check(string name, logic [67:0] act, logic [67:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        check("model_a", act_a, expect_out(ma));
        check("model_z", act_z, expect_out(mz));
    endtask

    task automatic tick();
        ma = mdl_step(ma, 4, rst, c0, c1);
        mz = mdl_step(mz, 0, rst, c0, c1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; c0 = 1'b0; c1 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit rst, c0, c1, g0, g1;
    } vec_t;

    vec_t tbl[8];

    initial begin
        ma = '{-1, 1, 0};
        mz = '{-1, 1, 0};
        rst = 1'b1; c0 = 1'b0; c1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0; wbd = 16'h1234;

        tbl[0] = '{1, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 1, 0};
        tbl[2] = '{0, 1, 0, 1, 0};
        tbl[3] = '{0, 0, 0, 0, 0};
        tbl[4] = '{0, 0, 1, 0, 1};
        tbl[5] = '{0, 1, 1, 0, 1};
        tbl[6] = '{0, 1, 0, 1, 0};
        tbl[7] = '{0, 0, 0, 0, 0};

        // Reset state
        tick();
        check("reset_out", act_a, 68'h0);
        check("reset_cnt", 68'(u_a.u_timer.count), 68'h0);

        for (int i = 0; i < 8; i++) begin
            rst = tbl[i].rst; c0 = tbl[i].c0; c1 = tbl[i].c1;
            tick();
            check("tbl_gnt", 68'({ba.o_m0_gnt, ba.o_m1_gnt}), 68'({tbl[i].g0, tbl[i].g1}));
            check_all();
        end

        // Single write from m0
        do_reset();
        c0 = 1'b1; we0 = 1'b1; a0 = 16'h0010; d0 = 16'hBEEF;
        check("pre_gnt_cyc", 68'(ba.o_wb_cyc), 68'h0);
        tick();
        check("wr_gnt", 68'({ba.o_m0_gnt, ba.o_m1_gnt, ba.o_wb_cyc}), 68'b101);
        check("wr_bus", 68'({ba.o_wb_we, ba.o_wb_addr, ba.o_wb_dat}), 68'({1'b1, 16'h0010, 16'hBEEF}));
        c0 = 1'b0; we0 = 1'b0;
        tick();

        // Simultaneous request, m0 holds 3 cycles then hands straight to m1
        do_reset();
        c0 = 1'b1; c1 = 1'b1;
        tick();
        check("tie_first", 68'({ba.o_m0_gnt, ba.o_m1_gnt}), 68'b10);
        tick(); tick();
        check_all();
        c0 = 1'b0;
        tick();
        check("handover", 68'({ba.o_m0_gnt, ba.o_m1_gnt, ba.o_wb_cyc}), 68'b011);
        c1 = 1'b0;
        tick();
        c0 = 1'b1; tick();
        c0 = 1'b0; tick();
        c0 = 1'b1; c1 = 1'b1;
        tick();
        check("tie_after_m0", 68'({ba.o_m0_gnt, ba.o_m1_gnt}), RR ? 68'b01 : 68'b10);
        check_all();
        c0 = 1'b0; c1 = 1'b0;
        tick();

        // m1 read from the uart
        do_reset();
        c1 = 1'b1; we1 = 1'b0; a1 = 16'h0001; wbd = 16'h0041;
        tick();
        check("rd_m1_dat", 68'(ba.o_m1_dat), 68'h0041);
        check("rd_m0_dat", 68'(ba.o_m0_dat), 68'h0);
        check("rd_addr", 68'({ba.o_wb_we, ba.o_wb_addr}), 68'h0001);
        c1 = 1'b0;
        tick();

        // Preemption after 4 contended cycles on the MAX_HOLD=4 instance
        do_reset();
        c0 = 1'b1;
        tick();
        c1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("hold_keep", 68'({ba.o_m0_gnt, ba.o_m1_gnt}), 68'b10);
        end
        tick();
        check("preempt", 68'({ba.o_m0_gnt, ba.o_m1_gnt}), 68'b01);
        check("no_preempt_z", 68'({bz.o_m0_gnt, bz.o_m1_gnt}), 68'b10);
        tick();
        c1 = 1'b0;
        tick();
        check("regrant_m0", 68'({ba.o_m0_gnt, ba.o_m1_gnt}), 68'b10);
        check_all();
        c0 = 1'b0;
        tick();

        // Reset while m1 owns the bus
        do_reset();
        c1 = 1'b1;
        tick();
        c0 = 1'b1; rst = 1'b1;
        tick();
        check("rst_mid", 68'({ba.o_m0_gnt, ba.o_m1_gnt, ba.o_wb_cyc}), 68'b000);
        rst = 1'b0;
        tick();
        check("rst_tie", 68'({ba.o_m0_gnt, ba.o_m1_gnt}), 68'b10);
        c0 = 1'b0; c1 = 1'b0;
        tick();

        // Long contention: unlimited hold never preempts and the counter saturates
        do_reset();
        c0 = 1'b1; c1 = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            check_all();
        end
        check("sat_gnt", 68'({bz.o_m0_gnt, bz.o_m1_gnt}), 68'b10);
        check("sat_cnt", 68'(u_z.u_timer.count), 68'd255);
        c0 = 1'b0; c1 = 1'b0;
        tick();

        // Randomized traffic with sticky requests
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(3) == 0) c0 = ~c0;
            if ($urandom_range(3) == 0) c1 = ~c1;
            rst = ($urandom_range(63) == 0);
            we0 = 1'($urandom); we1 = 1'($urandom);
            a0 = 16'($urandom); a1 = 16'($urandom);
            d0 = 16'($urandom); d1 = 16'($urandom);
            wbd = 16'($urandom);
            tick();
            check_all();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the d16 16-bit system bus (cyc/we/addr/dat, no ack). It lets the d16 CPU (master 0) and a second master (master 1, a DMA engine or debug loader) share one bus. That bus feeds syscon and the slaves (blkmem, uart). Each master gets a registered grant and holds the bus for as long as its cyc stays high, subject to an optional hold limit.

## Interface
- MAX_HOLD, 0: cycles a grant may be held while the other master waits; 0 = unlimited; legal range 0–255.
- i_clk  in  1  system clock; all state changes on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_m0_cyc / i_m1_cyc  in  1  master bus request; held high for the whole transfer.
- i_m0_we / i_m1_we  in  1  master write enable.
- i_m0_addr / i_m1_addr  in  16  master address.
- i_m0_dat / i_m1_dat  in  16  master write data.
- o_m0_dat / o_m1_dat  out  16  read data to master.
- o_m0_gnt / o_m1_gnt  out  1  grant; a master must treat its cycle as stalled while its grant is low.
- o_wb_cyc  out  1  bus cycle to syscon.
- o_wb_we  out  1  bus write enable.
- o_wb_addr  out  16  bus address.
- o_wb_dat  out  16  bus write data.
- i_wb_dat  in  16  read data from the slave mux.

## Operation
- States: IDLE, GNT0, GNT1.
- o_mX_gnt is registered and equals the state (GNT0 → o_m0_gnt=1, GNT1 → o_m1_gnt=1).
- IDLE transitions:
  - Only m0 requesting → GNT0.
  - Only m1 requesting → GNT1.
  - Both requesting → winner set by the policy in Configuration.
  - Neither requesting → stay in IDLE.
- GNTx transitions:
  - cyc_x high and not preempted → stay.
  - cyc_x low and other master requesting → GNTy directly; no IDLE bubble.
  - cyc_x low and no other request → IDLE.
- Bus outputs are a combinational mux of the granted master's we/addr/dat.
  - o_wb_cyc = granted master's cyc.
  - In IDLE: o_wb_cyc=0, o_wb_we=0, o_wb_addr=0, o_wb_dat=0.
- Read data: o_mX_dat = i_wb_dat while master X is granted, else 0.
- Hold counter (8 bit):
  - Clears on every grant change.
  - Increments each cycle in GNTx while the other master requests; saturates at 255.
  - When MAX_HOLD≠0, the counter reaches MAX_HOLD−1 and the other master is requesting → next state is GNTy (preemption).
  - The preempted master keeps its cyc high and waits for a regrant.
- last_gnt register: records the most recently granted master. Resets to 1 so that m0 wins the first tie.

## Timing
- Reset (next edge): state IDLE, both grants 0, counter 0, last_gnt=1; all bus outputs 0 from that edge.
- Reset mid-transfer: the grant drops at the reset edge with no completion. Masters must restart.
- Grant latency: cyc rising in cycle N (sampled at the edge ending N) → gnt high in cycle N+1. o_wb_cyc is also high in N+1.
- Handover: cyc_x falls in cycle N while cyc_y is high → gnt_y high in N+1, gnt_x low in N+1.
- Preemption: gnt_x falls after exactly MAX_HOLD contended cycles in GNTx.
- Read data is combinational from i_wb_dat. Slave read latency is the slave's own (blkmem is 1 cycle); the master owns the hold.

## Configuration
- BUS_ARBITER_RR_EN defined: round-robin. A tie in IDLE, or contention at handover, goes to the master that is not last_gnt.
- BUS_ARBITER_RR_EN undefined: fixed priority. m0 always wins a tie; last_gnt is still maintained but ignored.
- MAX_HOLD preemption applies in both modes.

## Structure
- Package d16_bus_pkg holds:
  - ADDR_W=16, DAT_W=16.
  - arb_state_t enum {IDLE, GNT0, GNT1}.
- Sub-module arb_hold_timer: holds the 8-bit counter and its clear/increment/saturate logic. Output o_expire = (MAX_HOLD≠0) && count==MAX_HOLD−1 && contended.
- Top-level bus_arbiter holds the FSM, last_gnt and the output muxes.

## Test plan
- Reset, then m0 cyc=1 we=1 addr=0x0010 dat=0xBEEF → o_m0_gnt=1 one cycle later; bus shows we=1, addr=0x0010, dat=0xBEEF; o_m1_gnt=0.
- Both cyc rise together from IDLE, m0 releases after 3 cycles:
  - RR build → m0 granted first, m1 granted on the cycle after m0's cyc falls, no IDLE cycle.
  - Fixed build, m0 re-requests immediately → m0 wins again.
- m1 granted for a read of addr=0x0001 (uart) with i_wb_dat=0x0041 → o_m1_dat=0x0041, o_m0_dat=0.
- MAX_HOLD=4, m0 holds cyc permanently and m1 requests → o_m0_gnt falls after 4 contended cycles; o_m1_gnt high the next cycle; m0 is regranted after m1 releases.
- i_reset pulsed while in GNT1 with cyc high → next edge: both grants 0, o_wb_cyc=0; m0 wins the first tie after reset.
- MAX_HOLD=0, contended for 300 cycles → no preemption; counter saturates at 255 without wrap.
